// File: rtl/rtt_timestamper_pkg.sv
// rtt_timestamper_pkg: shared constants for the RTT probe timestamper.
//   - register chain widths, block tag and local register offsets
//   - parser FSM state encoding
//   - saturating word-index increment helper
package rtt_timestamper_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

  // Low address bits select a register inside the block, the rest is the tag.
  localparam int REG_ADDR_WIDTH = 6;
  localparam int RTT_TAG_WIDTH  = UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam logic [RTT_TAG_WIDTH-1:0] RTT_TAG = 17'h00A5B;

  // generic_regs places counters first, then software registers.
  localparam logic [REG_ADDR_WIDTH-1:0] CNT0_STAMPED  = 6'd0;
  localparam logic [REG_ADDR_WIDTH-1:0] SW0_CTRL      = 6'd1;
  localparam logic [REG_ADDR_WIDTH-1:0] SW1_ETHERTYPE = 6'd2;

  typedef enum logic {
    HDR = 1'b0,
    PKT = 1'b1
  } parse_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small FIFO whose head is visible on dout_o
// combinationally while not empty (no read latency).
//   clk_i, rst_n_i (sync, active-low)
//   din_i/wr_en_i          write side
//   rd_en_i/dout_o         read side (rd_en_i pops the current head)
//   full_o, nearly_full_o (one entry short of full), empty_o
module fallthrough_small_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             nearly_full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [DEPTH_BITS-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]         cnt_q;
  logic                        do_wr, do_rd;

  assign empty_o       = (cnt_q == '0);
  assign full_o        = (cnt_q == (DEPTH_BITS+1)'(DEPTH));
  assign nearly_full_o = (cnt_q >= (DEPTH_BITS+1)'(DEPTH-1));
  assign dout_o        = mem_q[rd_ptr_q];

  assign do_rd = rd_en_i && !empty_o;
  // A write into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/generic_regs.sv
// generic_regs: register-chain slave with NUM_CNT read-only event counters
// (local offsets 0..NUM_CNT-1) followed by NUM_SW read/write software
// registers. Requests whose tag does not match, or that are already acked,
// pass through one register stage unchanged.
//   clk_i, rst_i (sync, active-high)
//   reg_*_i / reg_*_o   register chain in/out
//   cnt_inc_i           +1 pulse per counter
//   sw_regs_o           software register contents
module generic_regs #(
  parameter int SRC_W   = 2,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int LOC_W   = 6,
  parameter int TAG_W   = ADDR_W - LOC_W,
  parameter logic [TAG_W-1:0] TAG = '0,
  parameter int NUM_CNT = 1,
  parameter int NUM_SW  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          reg_req_i,
  input  logic                          reg_ack_i,
  input  logic                          reg_rd_wr_L_i,
  input  logic [ADDR_W-1:0]             reg_addr_i,
  input  logic [DATA_W-1:0]             reg_data_i,
  input  logic [SRC_W-1:0]              reg_src_i,
  output logic                          reg_req_o,
  output logic                          reg_ack_o,
  output logic                          reg_rd_wr_L_o,
  output logic [ADDR_W-1:0]             reg_addr_o,
  output logic [DATA_W-1:0]             reg_data_o,
  output logic [SRC_W-1:0]              reg_src_o,
  input  logic [NUM_CNT-1:0]            cnt_inc_i,
  output logic [NUM_SW-1:0][DATA_W-1:0] sw_regs_o
);
  logic [NUM_CNT-1:0][DATA_W-1:0] cnt_q;
  logic [NUM_SW-1:0][DATA_W-1:0]  sw_q;
  logic                           hit;
  logic [LOC_W-1:0]               loc;
  logic [DATA_W-1:0]              rd_data;

  assign hit       = reg_req_i && !reg_ack_i && (reg_addr_i[ADDR_W-1:LOC_W] == TAG);
  assign loc       = reg_addr_i[LOC_W-1:0];
  assign sw_regs_o = sw_q;

  always_comb begin
    rd_data = DATA_W'(32'hDEAD_BEEF);  // unmapped offset
    for (int i = 0; i < NUM_CNT; i++)
      if (loc == LOC_W'(i)) rd_data = cnt_q[i];
    for (int i = 0; i < NUM_SW; i++)
      if (loc == LOC_W'(NUM_CNT + i)) rd_data = sw_q[i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_req_o     <= 1'b0;
      reg_ack_o     <= 1'b0;
      reg_rd_wr_L_o <= 1'b0;
      reg_addr_o    <= '0;
      reg_data_o    <= '0;
      reg_src_o     <= '0;
      cnt_q         <= '0;
      sw_q          <= '0;
    end else begin
      reg_req_o     <= reg_req_i;
      reg_rd_wr_L_o <= reg_rd_wr_L_i;
      reg_addr_o    <= reg_addr_i;
      reg_src_o     <= reg_src_i;
      reg_ack_o     <= reg_ack_i || hit;
      reg_data_o    <= (hit && reg_rd_wr_L_i) ? rd_data : reg_data_i;
      for (int i = 0; i < NUM_CNT; i++)
        if (cnt_inc_i[i]) cnt_q[i] <= cnt_q[i] + DATA_W'(1);
      for (int i = 0; i < NUM_SW; i++)
        if (hit && !reg_rd_wr_L_i && loc == LOC_W'(NUM_CNT + i)) sw_q[i] <= reg_data_i;
    end
  end

endmodule

// File: rtl/rtt_timestamper.sv
// rtt_timestamper: passes packets through unchanged, except that on RTT
// probe packets (data word 1 bits [31:16] == programmed EtherType, stamping
// enabled) data word TS_WORD is replaced by a free-running 64-bit cycle count
// taken in the cycle the word leaves the block.
//   clk, reset (sync, active-low)
//   in_*   upstream packet bus (in_rdy = FIFO not nearly full)
//   out_*  bus to stats (out_wr = out_rdy && FIFO not empty)
//   reg_*  register chain: SW0[0]=enable, SW1[15:0]=ethertype,
//          CNT0 = stamped packets
module rtt_timestamper
  import rtt_timestamper_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TS_WORD           = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           in_wr,
  output logic                           in_rdy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  fifo_empty, fifo_nearly_full, fifo_full;
  logic                  head_is_data;

  parse_state_e state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic         probe_q, probe_d;
  logic [63:0]  ts_q;
  logic         stamp_due;

  logic [1:0][CPCI_NF2_DATA_WIDTH-1:0] sw_regs;
  logic                                enable;
  logic [15:0]                         ethertype;
  logic                                unused_sw_bits;

  fallthrough_small_fifo #(
    .WIDTH      (CTRL_WIDTH + DATA_WIDTH),
    .DEPTH_BITS (2)
  ) u_in_fifo (
    .clk_i         (clk),
    .rst_n_i       (reset),
    .din_i         ({in_ctrl, in_data}),
    .wr_en_i       (in_wr),
    .rd_en_i       (out_wr),
    .dout_o        ({head_ctrl, head_data}),
    .full_o        (fifo_full),
    .nearly_full_o (fifo_nearly_full),
    .empty_o       (fifo_empty)
  );

  assign in_rdy       = !fifo_nearly_full;
  assign out_wr       = out_rdy && !fifo_empty;
  assign head_is_data = (head_ctrl == '0);

  // idx_q holds the data-word index of the word at the FIFO head while in
  // PKT; word 0 is the transition out of HDR, so PKT is entered with idx 1.
  assign stamp_due = (state_q == PKT) && probe_q && head_is_data
                     && (idx_q == 8'(TS_WORD));

  assign out_ctrl = head_ctrl;
  assign out_data = stamp_due ? DATA_WIDTH'(ts_q) : head_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    probe_d = probe_q;
    if (out_wr) begin
      case (state_q)
        HDR: begin
          if (head_is_data) begin
            state_d = PKT;
            idx_d   = 8'd1;
            probe_d = 1'b0;
          end
        end
        PKT: begin
          if (!head_is_data) begin
            state_d = HDR;
          end else begin
            idx_d = sat_inc8(idx_q);
            // Enable/ethertype are sampled only here, so a register write
            // never affects a packet already past word 1.
            if (idx_q == 8'd1)
              probe_d = enable && (head_data[31:16] == ethertype);
          end
        end
        default: state_d = HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HDR;
      idx_q   <= '0;
      probe_q <= 1'b0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      probe_q <= probe_d;
      ts_q    <= ts_q + 64'd1;
    end
  end

  generic_regs #(
    .SRC_W   (UDP_REG_SRC_WIDTH),
    .ADDR_W  (UDP_REG_ADDR_WIDTH),
    .DATA_W  (CPCI_NF2_DATA_WIDTH),
    .LOC_W   (REG_ADDR_WIDTH),
    .TAG_W   (RTT_TAG_WIDTH),
    .TAG     (RTT_TAG),
    .NUM_CNT (1),
    .NUM_SW  (2)
  ) u_regs (
    .clk_i         (clk),
    .rst_i         (~reset),
    .reg_req_i     (reg_req_in),
    .reg_ack_i     (reg_ack_in),
    .reg_rd_wr_L_i (reg_rd_wr_L_in),
    .reg_addr_i    (reg_addr_in),
    .reg_data_i    (reg_data_in),
    .reg_src_i     (reg_src_in),
    .reg_req_o     (reg_req_out),
    .reg_ack_o     (reg_ack_out),
    .reg_rd_wr_L_o (reg_rd_wr_L_out),
    .reg_addr_o    (reg_addr_out),
    .reg_data_o    (reg_data_out),
    .reg_src_o     (reg_src_out),
    .cnt_inc_i     (out_wr && stamp_due),
    .sw_regs_o     (sw_regs)
  );

  assign enable         = sw_regs[0][0];
  assign ethertype      = sw_regs[1][15:0];
  assign unused_sw_bits = ^{sw_regs[0][31:1], sw_regs[1][31:16], fifo_full};

endmodule

// File: tb/tb_rtt_timestamper.sv
module tb_rtt_timestamper;
  import rtt_timestamper_pkg::*;

  localparam int TS_WORD = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [22:0] reg_addr_in = '0;
  logic [31:0] reg_data_in = '0;
  logic [1:0]  reg_src_in = '0;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;

  rtt_timestamper #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .UDP_REG_SRC_WIDTH(2), .TS_WORD(TS_WORD)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference cycle count: zero in the cycle after a reset edge, +1 per clk.
  logic [63:0] tb_ts = '0;
  always @(posedge clk) tb_ts <= (!reset) ? 64'd0 : tb_ts + 64'd1;

  typedef struct {
    logic [7:0]  c;
    logic [63:0] d;
    bit          stamp;
  } exp_t;
  exp_t sb[$];

  bit          m_en = 1'b0;
  logic [15:0] m_eth = '0;
  int          m_cnt = 0;
  bit          bp_en = 1'b0;
  bit          saw_in_rdy_low = 1'b0;

  always @(posedge clk) begin
    #1;
    out_rdy = bp_en ? ($urandom_range(0, 1) != 0) : 1'b1;
  end

  exp_t        mon_e;
  logic [63:0] mon_d;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (in_rdy === 1'b0) saw_in_rdy_low = 1'b1;
      if (out_wr === 1'b1) begin
        tests++;
        assert (out_rdy === 1'b1) else begin
          fails++; $error("FAIL out_wr_no_rdy: out_rdy=%b required 1 when out_wr=1", out_rdy);
        end
        if (sb.size() == 0) begin
          tests++; fails++;
          $error("FAIL extra_word: got ctrl=%h data=%h, required no word", out_ctrl, out_data);
        end else begin
          mon_e = sb.pop_front();
          mon_d = mon_e.stamp ? tb_ts : mon_e.d;
          tests++;
          assert (out_data === mon_d && out_ctrl === mon_e.c) else begin
            fails++;
            $error("FAIL out_word: got ctrl=%h data=%h, required ctrl=%h data=%h (stamp=%0d)",
                   out_ctrl, out_data, mon_e.c, mon_d, mon_e.stamp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++; $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic reg_xfer(input logic rd, input logic [22:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic ack, output logic [22:0] aout);
    int g = 0;
    reg_req_in = 1'b1; reg_ack_in = 1'b0; reg_rd_wr_L_in = rd;
    reg_addr_in = addr; reg_data_in = wd; reg_src_in = 2'd1;
    tick();
    reg_req_in = 1'b0;
    while (reg_req_out !== 1'b1 && g < 20) begin tick(); g++; end
    if (g >= 20) chk("reg_timeout", 64'd0, 64'd1);
    rdata = reg_data_out; ack = reg_ack_out; aout = reg_addr_out;
    tick();
  endtask

  task automatic reg_wr(input logic [5:0] off, input logic [31:0] wd);
    logic [31:0] r; logic a; logic [22:0] ao;
    reg_xfer(1'b0, {RTT_TAG, off}, wd, r, a, ao);
  endtask

  task automatic reg_rd(input logic [5:0] off, output logic [31:0] rdata);
    logic a; logic [22:0] ao;
    reg_xfer(1'b1, {RTT_TAG, off}, 32'h0, rdata, a, ao);
  endtask

  task automatic send_word(input logic [7:0] c, input logic [63:0] d, input bit st);
    int g = 0;
    exp_t e;
    while (in_rdy !== 1'b1 && g < 500) begin in_wr = 1'b0; tick(); g++; end
    if (g >= 500) begin chk("in_rdy_timeout", 64'd0, 64'd1); return; end
    in_wr = 1'b1; in_ctrl = c; in_data = d;
    e.c = c; e.d = d; e.stamp = st;
    sb.push_back(e);
    tick();
    in_wr = 1'b0;
  endtask

  // One module header word then ndata data words, the last one being EOP.
  task automatic send_pkt(input int ndata, input logic [15:0] eth, input logic [63:0] w3);
    bit probe = 1'b0;
    logic [7:0]  c;
    logic [63:0] d;
    bit st;
    send_word(8'hFF, {32'hABCD_0000, 32'(ndata)}, 1'b0);
    for (int i = 0; i < ndata; i++) begin
      c = (i == ndata - 1) ? 8'h01 : 8'h00;
      d = {$urandom(), $urandom()};
      if (i == 1) d[31:16] = eth;
      if (i == 3) d = w3;
      if (i == 1 && c == 8'h00) probe = m_en && (eth == m_eth);
      st = probe && (i == TS_WORD) && (c == 8'h00);
      if (st) m_cnt++;
      send_word(c, d, st);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 3000) begin tick(); g++; end
    chk("drain_left", 64'(sb.size()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic chk_cnt(input string tag);
    logic [31:0] r;
    reg_rd(CNT0_STAMPED, r);
    chk(tag, 64'(r), 64'(m_cnt));
  endtask

  logic [31:0] rv;
  logic        ra;
  logic [22:0] rao;

  initial begin
    repeat (3) tick();
    // reset state, checked while reset is still held
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_reg_req", 64'(reg_req_out), 64'd0);
    chk("rst_reg_ack", 64'(reg_ack_out), 64'd0);
    reset = 1'b1;
    tick();
    chk_cnt("rst_cnt");
    reg_rd(SW0_CTRL, rv);      chk("rst_sw0", 64'(rv), 64'd0);
    reg_rd(SW1_ETHERTYPE, rv); chk("rst_sw1", 64'(rv), 64'd0);

    // foreign-tag request passes through unacked and unchanged
    reg_xfer(1'b1, {RTT_TAG + 17'd1, 6'd2}, 32'h1234_5678, rv, ra, rao);
    chk("pass_ack", 64'(ra), 64'd0);
    chk("pass_data", 64'(rv), 64'h1234_5678);
    chk("pass_addr", 64'(rao), 64'({RTT_TAG + 17'd1, 6'd2}));

    // disabled pass-through
    reg_wr(SW1_ETHERTYPE, 32'h0000_88B5); m_eth = 16'h88B5;
    reg_wr(SW0_CTRL, 32'h0); m_en = 1'b0;
    reg_rd(SW1_ETHERTYPE, rv); chk("sw1_rb", 64'(rv), 64'h88B5);
    for (int p = 0; p < 10; p++) send_pkt(8, 16'h88B5, 64'hDEADBEEF_00000000);
    drain();
    chk_cnt("dis_cnt");

    // enabled stamping
    reg_wr(SW0_CTRL, 32'h1); m_en = 1'b1;
    send_pkt(8, 16'h88B5, 64'hDEADBEEF_00000000);
    drain();
    chk_cnt("stamp_cnt");
    chk("stamp_cnt_abs", 64'(m_cnt), 64'd1);

    // non-probe ethertype
    send_pkt(8, 16'h0800, 64'hDEADBEEF_00000000);
    drain();
    chk_cnt("nonprobe_cnt");

    // short probes: EOP at idx 1, 2, 3, then a normal probe
    send_pkt(2, 16'h88B5, 64'h0);
    send_pkt(3, 16'h88B5, 64'h0);
    send_pkt(4, 16'h88B5, 64'h1111_2222_3333_4444);
    send_pkt(6, 16'h88B5, 64'h5555_6666_7777_8888);
    drain();
    chk_cnt("short_cnt");

    // long probe: idx saturates, so only one stamp
    send_pkt(300, 16'h88B5, 64'hCAFE_0000_0000_0000);
    drain();
    chk_cnt("long_cnt");

    // random backpressure
    bp_en = 1'b1; saw_in_rdy_low = 1'b0;
    for (int p = 0; p < 8; p++) send_pkt(5 + p, (p % 3 == 2) ? 16'h0800 : 16'h88B5, 64'(p));
    drain();
    bp_en = 1'b0;
    repeat (2) tick();
    chk("bp_in_rdy_low", 64'(saw_in_rdy_low), 64'd1);
    chk_cnt("bp_cnt");

    // reset at idx 2 of a probe
    send_word(8'hFF, 64'h0, 1'b0);
    send_word(8'h00, 64'h0, 1'b0);
    send_word(8'h00, 64'h0000_0000_88B5_0000, 1'b0);
    send_word(8'h00, 64'h2, 1'b0);
    reset = 1'b0;
    sb.delete();
    m_en = 1'b0; m_eth = '0; m_cnt = 0;
    tick();
    chk("mid_rst_out_wr", 64'(out_wr), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("mid_rst_reg_req", 64'(reg_req_out), 64'd0);
    reset = 1'b1;
    tick();
    chk_cnt("mid_rst_cnt");
    reg_rd(SW0_CTRL, rv); chk("mid_rst_sw0", 64'(rv), 64'd0);
    reg_wr(SW1_ETHERTYPE, 32'h0000_88B5); m_eth = 16'h88B5;
    reg_wr(SW0_CTRL, 32'h1); m_en = 1'b1;
    send_pkt(8, 16'h88B5, 64'hDEADBEEF_00000000);
    drain();
    chk_cnt("post_rst_cnt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
